int_to_float: RTL and testbench
===============================

// Module: int_to_float
// PURPOSE
//  Pipelined signed-integer to float converter; the inverse of the float-to-int block.
//  Accepts one two's-complement integer per enabled clock and emits the nearest float.
//  The optional exponent offset scales the result by 2^offset, for fixed-point inputs.
//  Sits on rasteriser/geometry datapaths where integer or fixed-point results re-enter float math.
// PARAMETERS
//  MANTISSA_SIZE  23  stored mantissa bits, hidden bit excluded
//  EXPONENT_SIZE  8   exponent bits; bias = 2^(EXPONENT_SIZE-1)-1
//  INT_SIZE       32  input integer width incl. sign; must be >= MANTISSA_SIZE+2
//  DELAY          0   extra register stages appended after the core pipeline
// PORTS
//  clk        in   1                          clock; all logic on rising edge
//  reset      in   1                          synchronous, active-high reset
//  ce         in   1                          clock enable; 0 freezes every stage, including DELAY
//  in_valid   in   1                          in/offset are valid this cycle
//  offset     in   EXPONENT_SIZE (signed)     result = in * 2^offset; captured with in
//  in         in   INT_SIZE                   signed two's-complement integer
//  out_valid  out  1                          out holds a conversion result
//  out        out  1+EXPONENT_SIZE+MANTISSA_SIZE  {sign, exponent, mantissa}
// BEHAVIOUR
//  Reset: every stage's valid and data clear to 0, so out_valid=0 and out=0 on the cycle after reset.
//   Reset takes effect regardless of ce. Conversions in flight when reset asserts are discarded.
//  Latency: 3+DELAY enabled cycles. Throughput: 1 per enabled cycle. Bubbles (in_valid=0) propagate.
//   out holds its last value while out_valid=0.
//  ce=0: no register updates; out and out_valid hold. ce gates stage advance; in_valid gates nothing.
//  Stage 1: sign = in[INT_SIZE-1]; mag = sign ? -in : in, held in INT_SIZE bits unsigned.
//   INT_MIN gives mag = 2^(INT_SIZE-1), which is correct. Register sign, mag, offset, zero=(in==0).
//  Stage 2: msb = index of the leading one of mag (0..INT_SIZE-1), via a priority encoder.
//   Left-align: norm = mag << (INT_SIZE-1-msb). Register norm, msb, sign, offset, zero.
//  Stage 3: mant = norm[INT_SIZE-2 -: MANTISSA_SIZE].
//   g = next lower bit of norm, or 0 if none.
//   Round to nearest, ties away from zero: mant += g (sticky bits are ignored because ties round up).
//   Mantissa carry-out: mant = 0 and msb += 1.
//   e = msb + bias + offset, computed signed in EXPONENT_SIZE+2 bits.
//   zero       -> out = 0 (+0.0) for any offset.
//   e <= 0     -> flush to signed zero {sign, 0, 0}; no subnormals are produced.
//   e >= 2^EXPONENT_SIZE-1 -> signed infinity {sign, all-ones, 0}.
//   otherwise  -> {sign, e[EXPONENT_SIZE-1:0], mant}.
//  DELAY stages: a plain shift of {valid, out}, all under ce and reset.
//  Integers narrower than the mantissa convert exactly. Rounding happens only if msb > MANTISSA_SIZE.
// TESTING
//  1. Defaults, offset=0:
//     in=1 -> 0x3F800000; in=-1 -> 0xBF800000; in=0 -> 0x00000000.
//     out_valid rises exactly 3 cycles after in_valid.
//  2. Rounding:
//     in=16777217 (2^24+1) -> 0x4B800001 (tie away from zero).
//     in=0x7FFFFFFF -> 0x4F000000 (mantissa carry bumps the exponent).
//     in=0x80000000 -> 0xCF000000.
//  3. Offset:
//     in=3, offset=-1 -> 0x3FC00000 (1.5).
//     in=1, offset=-127 -> 0x00000000 (flush).
//     in=0x40000000, offset=127 -> 0x7F800000 (inf).
//     in=-5, offset=127 -> 0xFF800000 (-inf).
//  4. Back-to-back:
//     Random stream with in_valid every cycle and random bubbles.
//     out matches the reference model in order; bubbles appear as out_valid=0 in the same slots.
//  5. Stall: deassert ce for 5 cycles with 3 items in flight.
//     out and out_valid are frozen. On resume, the items emerge in order with no loss or duplication.
//  6. Reset mid-stream with the pipe full: next cycle out_valid=0 and out=0.
//     No stale result appears afterwards. Repeat with DELAY=2: latency becomes 5.

Source files
------------

// File: rtl/int_to_float_if.sv
// Conversion stream between a producer and the int_to_float block.
// The master drives integers in; the slave returns packed floats.
interface int_to_float_if #(
    parameter int unsigned EXPONENT_SIZE = 8,
    parameter int unsigned MANTISSA_SIZE = 23,
    parameter int unsigned INT_SIZE      = 32
);
    logic                                 in_valid;
    logic [EXPONENT_SIZE-1:0]             offset;
    logic [INT_SIZE-1:0]                  in;
    logic                                 out_valid;
    logic [EXPONENT_SIZE+MANTISSA_SIZE:0] out;

    modport master (
        output in_valid,
        output offset,
        output in,
        input  out_valid,
        input  out
    );

    modport slave (
        input  in_valid,
        input  offset,
        input  in,
        output out_valid,
        output out
    );
endinterface

// File: rtl/int_to_float.sv
// Pipelined signed-integer to float converter: magnitude, normalise, round/pack,
// then DELAY optional output stages. Result is in * 2^offset.
module int_to_float #(
    parameter int unsigned MANTISSA_SIZE = 23,
    parameter int unsigned EXPONENT_SIZE = 8,
    parameter int unsigned INT_SIZE      = 32,
    parameter int unsigned DELAY         = 0
) (
    input logic           clk,
    input logic           reset,
    input logic           ce,
    int_to_float_if.slave bus
);
    localparam int unsigned OutW = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
    localparam int unsigned MsbW = $clog2(INT_SIZE);
    localparam int unsigned ExpW = EXPONENT_SIZE + 2;
    localparam logic signed [ExpW-1:0] BiasE  = ExpW'(2 ** (EXPONENT_SIZE - 1) - 1);
    localparam logic signed [ExpW-1:0] MaxExp = ExpW'(2 ** EXPONENT_SIZE - 1);
    localparam int unsigned GuardIdx = INT_SIZE - 2 - MANTISSA_SIZE;

    // Stage 1: sign and magnitude
    logic                     s1_valid_q;
    logic                     s1_sign_q;
    logic [INT_SIZE-1:0]      s1_mag_q;
    logic [EXPONENT_SIZE-1:0] s1_offset_q;
    logic                     s1_zero_q;
    logic [INT_SIZE-1:0]      mag_d;

    // INT_MIN negates to itself, which read unsigned is exactly 2^(INT_SIZE-1).
    always_comb begin
        mag_d = bus.in[INT_SIZE-1] ? -bus.in : bus.in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s1_offset_q <= '0;
            s1_zero_q   <= 1'b0;
        end else if (ce) begin
            s1_valid_q  <= bus.in_valid;
            s1_sign_q   <= bus.in[INT_SIZE-1];
            s1_mag_q    <= mag_d;
            s1_offset_q <= bus.offset;
            s1_zero_q   <= (bus.in == '0);
        end
    end

    // Stage 2: leading-one detect and left-align
    logic                     s2_valid_q;
    logic                     s2_sign_q;
    logic [INT_SIZE-1:0]      s2_norm_q;
    logic [MsbW-1:0]          s2_msb_q;
    logic [EXPONENT_SIZE-1:0] s2_offset_q;
    logic                     s2_zero_q;
    logic [MsbW-1:0]          msb_d;
    logic [INT_SIZE-1:0]      norm_d;

    always_comb begin
        msb_d = '0;
        for (int i = 0; i < int'(INT_SIZE); i++) begin
            if (s1_mag_q[i]) begin
                msb_d = MsbW'(i);
            end
        end
        norm_d = s1_mag_q << (MsbW'(INT_SIZE - 1) - msb_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_norm_q   <= '0;
            s2_msb_q    <= '0;
            s2_offset_q <= '0;
            s2_zero_q   <= 1'b0;
        end else if (ce) begin
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_norm_q   <= norm_d;
            s2_msb_q    <= msb_d;
            s2_offset_q <= s1_offset_q;
            s2_zero_q   <= s1_zero_q;
        end
    end

    // Stage 3: round (ties away from zero), exponent, special cases, pack
    logic                     s3_valid_q;
    logic [OutW-1:0]          s3_out_q;
    logic [OutW-1:0]          s3_out_d;
    logic [MANTISSA_SIZE:0]   mant_rnd;
    logic                     guard;
    logic signed [ExpW-1:0]   exp_s;
    logic                     unused_norm;

    // Hidden bit and sub-guard bits carry no information once rounding is done.
    assign unused_norm = ^s2_norm_q;

    always_comb begin
        guard    = s2_norm_q[GuardIdx];
        mant_rnd = {1'b0, s2_norm_q[INT_SIZE-2 -: MANTISSA_SIZE]}
                 + {{MANTISSA_SIZE{1'b0}}, guard};
        // A carry out of the mantissa leaves mant_rnd low bits at zero and bumps the exponent.
        exp_s    = $signed({{(ExpW - MsbW){1'b0}}, s2_msb_q})
                 + $signed({{(ExpW - 1){1'b0}}, mant_rnd[MANTISSA_SIZE]})
                 + BiasE
                 + $signed({{2{s2_offset_q[EXPONENT_SIZE-1]}}, s2_offset_q});
        if (s2_zero_q) begin
            s3_out_d = '0;
        end else if (exp_s <= 0) begin
            s3_out_d = {s2_sign_q, {(EXPONENT_SIZE + MANTISSA_SIZE){1'b0}}};
        end else if (exp_s >= MaxExp) begin
            s3_out_d = {s2_sign_q, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
        end else begin
            s3_out_d = {s2_sign_q, exp_s[EXPONENT_SIZE-1:0], mant_rnd[MANTISSA_SIZE-1:0]};
        end
    end

    // Output data only moves on a valid result, so it holds across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid_q <= 1'b0;
            s3_out_q   <= '0;
        end else if (ce) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_out_q <= s3_out_d;
            end
        end
    end

    if (DELAY == 0) begin : g_no_delay
        assign bus.out_valid = s3_valid_q;
        assign bus.out       = s3_out_q;
    end else begin : g_delay
        logic [DELAY-1:0] dly_valid_q;
        logic [OutW-1:0]  dly_out_q [DELAY];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < int'(DELAY); i++) begin
                    dly_valid_q[i] <= 1'b0;
                    dly_out_q[i]   <= '0;
                end
            end else if (ce) begin
                dly_valid_q[0] <= s3_valid_q;
                dly_out_q[0]   <= s3_out_q;
                for (int i = 1; i < int'(DELAY); i++) begin
                    dly_valid_q[i] <= dly_valid_q[i-1];
                    dly_out_q[i]   <= dly_out_q[i-1];
                end
            end
        end

        assign bus.out_valid = dly_valid_q[DELAY-1];
        assign bus.out       = dly_out_q[DELAY-1];
    end
endmodule

// File: tb/tb_int_to_float.sv
// Directed bench for int_to_float; runs a DELAY=0 and a DELAY=2 instance in lockstep.
module tb_int_to_float;
    logic clk = 1'b0;
    logic reset;
    logic ce;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    always #5 clk = ~clk;

    int_to_float_if if0 ();
    int_to_float_if if2 ();

    int_to_float #(.DELAY(0)) dut0 (.clk(clk), .reset(reset), .ce(ce), .bus(if0.slave));
    int_to_float #(.DELAY(2)) dut2 (.clk(clk), .reset(reset), .ce(ce), .bus(if2.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] off, input logic [31:0] x);
        if0.in_valid = v;
        if0.offset   = off;
        if0.in       = x;
        if2.in_valid = v;
        if2.offset   = off;
        if2.in       = x;
    endtask

    // Sends one item and reports the first valid output and its latency on each instance.
    task automatic convert(input logic [31:0] x, input logic [7:0] off,
                           output int lat0, output logic [31:0] o0,
                           output int lat2, output logic [31:0] o2);
        lat0 = -1;
        lat2 = -1;
        o0   = 32'hDEADBEEF;
        o2   = 32'hDEADBEEF;
        drive(1'b1, off, x);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) drive(1'b0, 8'h00, 32'h0);
            if (lat0 < 0 && if0.out_valid === 1'b1) begin
                lat0 = k;
                o0   = if0.out;
            end
            if (lat2 < 0 && if2.out_valid === 1'b1) begin
                lat2 = k;
                o2   = if2.out;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce    = 1'b1;
        drive(1'b0, 8'h00, 32'h0);
        tick();
        tick();
        chk_cnt++;
        if (if0.out_valid !== 1'b0) $display("FAIL reset_valid0 got %b want 0", if0.out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (if0.out !== 32'h0) $display("FAIL reset_out0 got %h want 00000000", if0.out);
        else pass_cnt++;
        chk_cnt++;
        if (if2.out_valid !== 1'b0) $display("FAIL reset_valid2 got %b want 0", if2.out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (if2.out !== 32'h0) $display("FAIL reset_out2 got %h want 00000000", if2.out);
        else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] vin [3];
        logic [31:0] vexp [3];
        int lat0, lat2;
        logic [31:0] o0, o2;
        vin  = '{32'h1, 32'hFFFFFFFF, 32'h0};
        vexp = '{32'h3F800000, 32'hBF800000, 32'h00000000};
        for (int i = 0; i < 3; i++) begin
            convert(vin[i], 8'h00, lat0, o0, lat2, o2);
            chk_cnt++;
            if (o0 !== vexp[i]) $display("FAIL basic_out in=%h got %h want %h", vin[i], o0, vexp[i]);
            else pass_cnt++;
            chk_cnt++;
            if (lat0 !== 3) $display("FAIL basic_latency in=%h got %0d want 3", vin[i], lat0);
            else pass_cnt++;
        end
    endtask

    task automatic test_rounding();
        logic [31:0] vin [5];
        logic [31:0] vexp [5];
        int lat0, lat2;
        logic [31:0] o0, o2;
        vin  = '{32'h01000001, 32'h7FFFFFFF, 32'h80000000, 32'h01000000, 32'h01000003};
        vexp = '{32'h4B800001, 32'h4F000000, 32'hCF000000, 32'h4B800000, 32'h4B800002};
        for (int i = 0; i < 5; i++) begin
            convert(vin[i], 8'h00, lat0, o0, lat2, o2);
            chk_cnt++;
            if (o0 !== vexp[i]) $display("FAIL round_out in=%h got %h want %h", vin[i], o0, vexp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_offset();
        logic [31:0] vin [8];
        logic [7:0]  voff [8];
        logic [31:0] vexp [8];
        int lat0, lat2;
        logic [31:0] o0, o2;
        vin  = '{32'h3, 32'h1, 32'h40000000, 32'hFFFFFFFB,
                 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2};
        voff = '{8'hFF, 8'h81, 8'h7F, 8'h7F, 8'h81, 8'h05, 8'h7F, 8'h7F};
        vexp = '{32'h3FC00000, 32'h00000000, 32'h7F800000, 32'hFF800000,
                 32'h80000000, 32'h00000000, 32'h7F000000, 32'h7F800000};
        for (int i = 0; i < 8; i++) begin
            convert(vin[i], voff[i], lat0, o0, lat2, o2);
            chk_cnt++;
            if (o0 !== vexp[i])
                $display("FAIL offset_out in=%h off=%h got %h want %h", vin[i], voff[i], o0, vexp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic        v [10];
        logic [31:0] x [10];
        logic [7:0]  off [10];
        logic [31:0] e [10];
        logic [31:0] held0, held2;
        int j;
        v   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        x   = '{32'h1, 32'hFFFFFFFF, 32'h0, 32'h3, 32'h01000001,
                32'h0, 32'h0, 32'h80000000, 32'h2, 32'h01000003};
        off = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        e   = '{32'h3F800000, 32'hBF800000, 32'h0, 32'h3FC00000, 32'h4B800001,
                32'h0, 32'h0, 32'hCF000000, 32'h40000000, 32'h4B800002};
        held0 = e[0];
        held2 = e[0];
        for (int c = 0; c < 14; c++) begin
            if (c < 10) drive(v[c], off[c], x[c]);
            else drive(1'b0, 8'h00, 32'h0);
            tick();
            j = c - 2;
            if (j >= 0 && j < 10) begin
                if (v[j]) held0 = e[j];
                chk_cnt++;
                if (if0.out_valid !== v[j] || if0.out !== held0)
                    $display("FAIL b2b_dly0 slot=%0d got %b/%h want %b/%h",
                             j, if0.out_valid, if0.out, v[j], held0);
                else pass_cnt++;
            end
            j = c - 4;
            if (j >= 0 && j < 10) begin
                if (v[j]) held2 = e[j];
                chk_cnt++;
                if (if2.out_valid !== v[j] || if2.out !== held2)
                    $display("FAIL b2b_dly2 slot=%0d got %b/%h want %b/%h",
                             j, if2.out_valid, if2.out, v[j], held2);
                else pass_cnt++;
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_stall();
        logic        e0v [5];
        logic [31:0] e0o [5];
        logic        e2v [5];
        logic [31:0] e2o [5];
        e0v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        e0o = '{32'hBF800000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
        e2v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        e2o = '{32'h0, 32'h3F800000, 32'hBF800000, 32'h40000000, 32'h40000000};
        drive(1'b1, 8'h00, 32'h1);
        tick();
        drive(1'b1, 8'h00, 32'hFFFFFFFF);
        tick();
        drive(1'b1, 8'h00, 32'h2);
        tick();
        ce = 1'b0;
        drive(1'b1, 8'h00, 32'h7);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_cnt++;
            if (if0.out_valid !== 1'b1 || if0.out !== 32'h3F800000)
                $display("FAIL stall_freeze0 cyc=%0d got %b/%h want 1/3f800000",
                         k, if0.out_valid, if0.out);
            else pass_cnt++;
            chk_cnt++;
            if (if2.out_valid !== 1'b0)
                $display("FAIL stall_freeze2 cyc=%0d got %b want 0", k, if2.out_valid);
            else pass_cnt++;
        end
        ce = 1'b1;
        drive(1'b0, 8'h00, 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_cnt++;
            if (if0.out_valid !== e0v[k] || if0.out !== e0o[k])
                $display("FAIL stall_resume0 cyc=%0d got %b/%h want %b/%h",
                         k, if0.out_valid, if0.out, e0v[k], e0o[k]);
            else pass_cnt++;
            chk_cnt++;
            if (if2.out_valid !== e2v[k] || (k > 0 && if2.out !== e2o[k]))
                $display("FAIL stall_resume2 cyc=%0d got %b/%h want %b/%h",
                         k, if2.out_valid, if2.out, e2v[k], e2o[k]);
            else pass_cnt++;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int stale0 = 0;
        int stale2 = 0;
        int lat0, lat2;
        logic [31:0] o0, o2;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'h00, 32'(k + 1));
            tick();
        end
        // Reset asserted while stalled: must still clear everything.
        ce    = 1'b0;
        reset = 1'b1;
        drive(1'b1, 8'h00, 32'h5);
        tick();
        chk_cnt++;
        if (if0.out_valid !== 1'b0 || if0.out !== 32'h0)
            $display("FAIL midreset0 got %b/%h want 0/00000000", if0.out_valid, if0.out);
        else pass_cnt++;
        chk_cnt++;
        if (if2.out_valid !== 1'b0 || if2.out !== 32'h0)
            $display("FAIL midreset2 got %b/%h want 0/00000000", if2.out_valid, if2.out);
        else pass_cnt++;
        reset = 1'b0;
        ce    = 1'b1;
        drive(1'b0, 8'h00, 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (if0.out_valid !== 1'b0) stale0++;
            if (if2.out_valid !== 1'b0) stale2++;
        end
        chk_cnt++;
        if (stale0 != 0) $display("FAIL stale0 got %0d valid cycles want 0", stale0);
        else pass_cnt++;
        chk_cnt++;
        if (stale2 != 0) $display("FAIL stale2 got %0d valid cycles want 0", stale2);
        else pass_cnt++;
        convert(32'h3, 8'h00, lat0, o0, lat2, o2);
        chk_cnt++;
        if (lat0 !== 3 || o0 !== 32'h40400000)
            $display("FAIL post_reset0 got lat=%0d out=%h want lat=3 out=40400000", lat0, o0);
        else pass_cnt++;
        chk_cnt++;
        if (lat2 !== 5 || o2 !== 32'h40400000)
            $display("FAIL post_reset2 got lat=%0d out=%h want lat=5 out=40400000", lat2, o2);
        else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_offset();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
